lpr_status_snapshot_ctrl: RTL and testbench
===========================================

// Module: lpr_status_snapshot_ctrl
// PURPOSE
//   Sequences the 32-bit status word driven into the HPS-visible status PIO input port.
//   Aggregates LPR pipeline events into sticky flags and a frame counter.
//   Runs a request/hold/release snapshot handshake so that HPS reads a coherent, frozen word.
//   On release, clears only the events that HPS has already seen.
// PARAMETERS
//   TIMEOUT_CYCLES  50000000  max HOLD duration before forced release (1 s @ 50 MHz)
//   TIMEOUT_W       26        width of hold timeout counter (must hold TIMEOUT_CYCLES)
//   CLR_ON_READ     1         1: release clears captured sticky bits/count; 0: never clears
// PORTS
//   clk           in   1   system clock
//   reset_n       in   1   asynchronous active-low reset
//   frame_done    in   1   1-cycle pulse per processed frame
//   plate_valid   in   1   1-cycle pulse per recognised plate
//   engine_busy   in   1   level, OCR engine busy
//   err_in        in   8   per-source 1-cycle error pulses
//   snap_req      in   1   level from HPS control PIO, same clock domain
//   status_word   out  32  registered word to status PIO in_port
//   err_pending   out  1   level, OR of sticky error bits (live, never frozen)
// BEHAVIOUR
//   Reset: all regs 0, status_word=0, err_pending=0, state=LIVE, armed=0.
//   Word layout: [31] snap_valid, [30:29] seq, [28] hold_timeout, [27] engine_busy,
//     [26] plate_seen, [25:24] 0, [23:16] err_sticky, [15:0] frame_cnt.
//   Event accumulation runs every cycle in every state:
//     - err_sticky |= err_in
//     - plate_seen set by plate_valid
//     - frame_cnt += frame_done, saturating at 16'hFFFF
//   armed: set in any cycle with snap_req=0; cleared on entry to CAPTURE.
//   FSM:
//     LIVE: status_word <= live fields (1-cycle latency), bit31=0.
//       If snap_req & armed -> CAPTURE.
//     CAPTURE (1 cycle):
//       - snap_reg <= live fields (including this cycle's events)
//       - seq <= seq+1 (wraps 3->0)
//       - tmo_cnt <= 0
//       - armed <= 0
//       - -> HOLD
//     HOLD: status_word = snap_reg with bit31=1, seq; frozen; tmo_cnt++.
//       - snap_req=0 -> RELEASE.
//       - Else if tmo_cnt==TIMEOUT_CYCLES-1 -> set hold_timeout, -> LIVE, no clear.
//     RELEASE (1 cycle), when CLR_ON_READ=1:
//       - err_sticky <= (err_sticky & ~snap_err) | err_in
//       - plate_seen <= (plate_seen & ~snap_plate) | plate_valid
//       - frame_cnt <= frame_cnt - snap_cnt + frame_done, saturating
//       - hold_timeout <= 0
//       - -> LIVE
//   Simultaneous events: a pulse arriving in the CAPTURE, HOLD or RELEASE cycle is never lost.
//     It stays set or counted for the next snapshot.
//   engine_busy is sampled into snap_reg at CAPTURE and is never sticky.
//   After a timeout, a new capture requires snap_req to go low then high; a held-high req never re-triggers.
//   Reset asserted mid-HOLD: immediate return to LIVE and zeroed outputs; pending events discarded.
// TESTING
//   1. Reset, then 3 frame_done pulses, snap_req=0.
//      -> status_word=32'h0000_0003, bit31=0.
//   2. err_in=8'h05, snap_req 0->1.
//      -> 2 cycles later status_word[31]=1, [30:29]=1, [23:16]=8'h05; word frozen while req=1.
//   3. During HOLD, err_in=8'h02 and 2 frame_done; then drop req.
//      -> LIVE shows err=8'h02 and frame_cnt=2; err_pending=1 throughout.
//   4. Hold req high for TIMEOUT_CYCLES (bench value 16).
//      -> bit28=1, bit31=0, no clear; req kept high gives no new capture; toggle gives seq+1.
//   5. 70000 frame_done pulses. -> frame_cnt saturates at 16'hFFFF.
//      Snapshot plus release -> count equals pulses after capture.
//   6. Assert reset_n=0 in HOLD. -> status_word=0 asynchronously.
//      After release, req held high gives no capture until req goes low.

Source files
------------

// File: rtl/lpr_status_snapshot_ctrl.sv
// Builds the HPS status word from sticky LPR events and a saturating frame count, with a
// request/hold/release snapshot handshake that freezes the word while HPS reads it.
module lpr_status_snapshot_ctrl #(
   parameter int unsigned TIMEOUT_CYCLES = 50000000,
   parameter int unsigned TIMEOUT_W      = 26,
   parameter bit          CLR_ON_READ    = 1'b1
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        frame_done,
   input  logic        plate_valid,
   input  logic        engine_busy,
   input  logic [7:0]  err_in,
   input  logic        snap_req,
   output logic [31:0] status_word,
   output logic        err_pending
);

   typedef enum logic [1:0] {ST_LIVE, ST_CAPTURE, ST_HOLD, ST_RELEASE} state_t;

   localparam logic [TIMEOUT_W-1:0] TMO_LAST = TIMEOUT_W'(TIMEOUT_CYCLES - 1);

   state_t               state;
   logic                 armed;
   logic [1:0]           seq;
   logic                 hold_timeout;
   logic [7:0]           err_sticky;
   logic                 plate_seen;
   logic [15:0]          frame_cnt;
   logic [7:0]           snap_err;
   logic                 snap_plate;
   logic [15:0]          snap_cnt;
   logic [TIMEOUT_W-1:0] tmo_cnt;

   logic                 clr;
   logic [7:0]           err_nx;
   logic                 plate_nx;
   logic [15:0]          cnt_base;
   logic [16:0]          cnt_sum;
   logic [15:0]          cnt_nx;
   logic                 tmo_nx;
   logic [31:0]          live_word;

   // Next-state event fields always include this cycle's pulses, so nothing is lost at
   // capture or release; on release only what the snapshot held is subtracted.
   always_comb begin
      clr       = CLR_ON_READ && (state == ST_RELEASE);
      err_nx    = (clr ? (err_sticky & ~snap_err) : err_sticky) | err_in;
      plate_nx  = (clr ? (plate_seen & ~snap_plate) : plate_seen) | plate_valid;
      cnt_base  = clr ? (frame_cnt - snap_cnt) : frame_cnt;
      cnt_sum   = {1'b0, cnt_base} + {16'd0, frame_done};
      cnt_nx    = cnt_sum[16] ? 16'hFFFF : cnt_sum[15:0];
      tmo_nx    = hold_timeout;
      if (clr) begin
         tmo_nx = 1'b0;
      end else if (state == ST_HOLD && snap_req && tmo_cnt == TMO_LAST) begin
         tmo_nx = 1'b1;
      end
      live_word = {1'b0, seq, tmo_nx, engine_busy, plate_nx, 2'b00, err_nx, cnt_nx};
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state        <= ST_LIVE;
         armed        <= 1'b0;
         seq          <= 2'd0;
         hold_timeout <= 1'b0;
         err_sticky   <= 8'd0;
         plate_seen   <= 1'b0;
         frame_cnt    <= 16'd0;
         snap_err     <= 8'd0;
         snap_plate   <= 1'b0;
         snap_cnt     <= 16'd0;
         tmo_cnt      <= '0;
         status_word  <= 32'd0;
         err_pending  <= 1'b0;
      end else begin
         err_sticky   <= err_nx;
         plate_seen   <= plate_nx;
         frame_cnt    <= cnt_nx;
         hold_timeout <= tmo_nx;
         err_pending  <= |err_nx;
         // A request held high across a timeout or reset must drop before it can fire again.
         armed        <= ~snap_req | (armed & ~((state == ST_LIVE) & snap_req));
         case (state)
            ST_LIVE: begin
               status_word <= live_word;
               if (snap_req && armed) state <= ST_CAPTURE;
            end
            ST_CAPTURE: begin
               snap_err    <= err_nx;
               snap_plate  <= plate_nx;
               snap_cnt    <= cnt_nx;
               seq         <= seq + 2'd1;
               tmo_cnt     <= '0;
               status_word <= {1'b1, seq + 2'd1, tmo_nx, engine_busy, plate_nx, 2'b00,
                               err_nx, cnt_nx};
               state       <= ST_HOLD;
            end
            ST_HOLD: begin
               if (!snap_req) begin
                  state <= ST_RELEASE;
               end else if (tmo_cnt == TMO_LAST) begin
                  state <= ST_LIVE;
               end else begin
                  tmo_cnt <= tmo_cnt + 1'b1;
               end
            end
            ST_RELEASE: begin
               status_word <= live_word;
               state       <= ST_LIVE;
            end
            default: state <= ST_LIVE;
         endcase
      end
   end

endmodule

// File: tb/tb_lpr_status_snapshot_ctrl.sv
// Bench for lpr_status_snapshot_ctrl: directed vector table, random traffic against an
// event-level reference model, and hand sequences for timeout, saturation and reset.
`timescale 1ns/1ps
module tb_lpr_status_snapshot_ctrl;

   localparam int TMO = 16;
   localparam int P_LIVE = 0, P_CAP = 1, P_HOLD = 2, P_REL = 3;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        frame_done = 1'b0;
   logic        plate_valid = 1'b0;
   logic        engine_busy = 1'b0;
   logic [7:0]  err_in = 8'd0;
   logic        snap_req = 1'b0;
   logic [31:0] status_word;
   logic        err_pending;

   int n_cmp = 0;
   int n_bad = 0;

   lpr_status_snapshot_ctrl #(
      .TIMEOUT_CYCLES(TMO),
      .TIMEOUT_W     (5),
      .CLR_ON_READ   (1'b1)
   ) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .frame_done (frame_done),
      .plate_valid(plate_valid),
      .engine_busy(engine_busy),
      .err_in     (err_in),
      .snap_req   (snap_req),
      .status_word(status_word),
      .err_pending(err_pending)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, got timeout required completion");
      $fatal(1, "watchdog");
   end

   // Reference model: live event totals, the copy HPS was shown, and how long it has held.
   int m_err, m_plate, m_cnt, m_tmo, m_seq, m_armed, m_phase, m_age;
   int s_err, s_plate, s_cnt;
   logic [31:0] m_word;
   logic        m_pend;

   function automatic logic [31:0] pack(int v, int sq, int tm, int bz, int pl, int er, int cn);
      return (32'(v) << 31) | (32'(sq) << 29) | (32'(tm) << 28) | (32'(bz) << 27) |
             (32'(pl) << 26) | (32'(er) << 16) | 32'(cn);
   endfunction

   function automatic int sat16(int x);
      return (x > 65535) ? 65535 : x;
   endfunction

   task automatic model_reset();
      m_err = 0; m_plate = 0; m_cnt = 0; m_tmo = 0; m_seq = 0; m_armed = 0;
      m_phase = P_LIVE; m_age = 0; s_err = 0; s_plate = 0; s_cnt = 0;
      m_word = 32'd0; m_pend = 1'b0;
   endtask

   task automatic model_step();
      int e, p, f, b, ne, np, nc;
      e  = int'(err_in); p = int'(plate_valid); f = int'(frame_done); b = int'(engine_busy);
      ne = m_err | e;
      np = m_plate | p;
      nc = sat16(m_cnt + f);
      case (m_phase)
         P_LIVE: begin
            m_word = pack(0, m_seq, m_tmo, b, np, ne, nc);
            if (snap_req && m_armed != 0) begin
               m_phase = P_CAP;
               m_armed = 0;
            end
         end
         P_CAP: begin
            s_err = ne; s_plate = np; s_cnt = nc;
            m_seq = (m_seq + 1) % 4;
            m_word = pack(1, m_seq, m_tmo, b, np, ne, nc);
            m_age = 0;
            m_phase = P_HOLD;
         end
         P_HOLD: begin
            m_age++;
            if (!snap_req) m_phase = P_REL;
            else if (m_age == TMO) begin
               m_tmo = 1;
               m_phase = P_LIVE;
            end
         end
         default: begin
            ne = (m_err & ~s_err) | e;
            np = (m_plate & ~s_plate) | p;
            nc = sat16(m_cnt - s_cnt + f);
            m_tmo = 0;
            m_word = pack(0, m_seq, 0, b, np, ne, nc);
            m_phase = P_LIVE;
         end
      endcase
      if (!snap_req) m_armed = 1;
      m_err = ne; m_plate = np; m_cnt = nc;
      m_pend = (ne != 0);
   endtask

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h required %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      model_step();
      #1;
      chk("model_word", status_word, m_word);
      chk("model_pend", {31'd0, err_pending}, {31'd0, m_pend});
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      frame_done = 1'b0; plate_valid = 1'b0; engine_busy = 1'b0; err_in = 8'd0;
      model_reset();
      repeat (3) @(posedge clk);
      @(negedge clk);
      reset_n = 1'b1;
   endtask

   typedef struct {
      logic        frame;
      logic        plate;
      logic        busy;
      logic [7:0]  err;
      logic        req;
      logic [31:0] word;
      logic        pend;
   } vec_t;

   function automatic vec_t mk(logic f, logic p, logic b, logic [7:0] e, logic r,
                               logic [31:0] w, logic pd);
      vec_t v;
      v.frame = f; v.plate = p; v.busy = b; v.err = e; v.req = r; v.word = w; v.pend = pd;
      return v;
   endfunction

   vec_t tbl[11];

   initial begin
      tbl[0]  = mk(1, 0, 0, 8'h00, 0, 32'h0000_0001, 0);
      tbl[1]  = mk(1, 0, 0, 8'h00, 0, 32'h0000_0002, 0);
      tbl[2]  = mk(1, 0, 0, 8'h00, 0, 32'h0000_0003, 0);
      tbl[3]  = mk(0, 1, 0, 8'h00, 0, 32'h0400_0003, 0);
      tbl[4]  = mk(0, 0, 0, 8'h05, 1, 32'h0405_0003, 1);
      tbl[5]  = mk(0, 0, 1, 8'h00, 1, 32'hAC05_0003, 1);
      tbl[6]  = mk(1, 0, 0, 8'h02, 1, 32'hAC05_0003, 1);
      tbl[7]  = mk(1, 0, 0, 8'h00, 1, 32'hAC05_0003, 1);
      tbl[8]  = mk(0, 0, 0, 8'h00, 0, 32'hAC05_0003, 1);
      tbl[9]  = mk(0, 0, 0, 8'h00, 0, 32'h2002_0002, 1);
      tbl[10] = mk(0, 0, 1, 8'h00, 0, 32'h2802_0002, 1);

      snap_req = 1'b0;
      do_reset();
      #1;
      chk("reset_word", status_word, 32'd0);
      chk("reset_pend", {31'd0, err_pending}, 32'd0);

      for (int i = 0; i < 11; i++) begin
         frame_done = tbl[i].frame; plate_valid = tbl[i].plate; engine_busy = tbl[i].busy;
         err_in = tbl[i].err; snap_req = tbl[i].req;
         step();
         chk($sformatf("tbl_word[%0d]", i), status_word, tbl[i].word);
         chk($sformatf("tbl_pend[%0d]", i), {31'd0, err_pending}, {31'd0, tbl[i].pend});
      end

      // Random traffic; long request runs make timeouts happen too.
      for (int i = 0; i < 3000; i++) begin
         frame_done  = ($urandom_range(0, 2) == 0);
         plate_valid = ($urandom_range(0, 7) == 0);
         engine_busy = $urandom_range(0, 1) != 0;
         err_in      = ($urandom_range(0, 15) == 0) ? 8'($urandom) : 8'd0;
         if ($urandom_range(0, 39) == 0) snap_req = ~snap_req;
         step();
      end

      // Timeout: held request never re-triggers; a fresh edge captures with seq+1.
      frame_done = 1'b0; plate_valid = 1'b0; engine_busy = 1'b0; err_in = 8'd0;
      snap_req = 1'b1;
      do_reset();
      repeat (5) step();
      chk("req_high_after_reset_no_cap", {31'd0, status_word[31]}, 32'd0);
      snap_req = 1'b0; step();
      snap_req = 1'b1; step(); step();
      chk("cap_valid_seq", {29'd0, status_word[31:29]}, 32'd5);
      repeat (22) step();
      chk("timeout_flags", {30'd0, status_word[31], status_word[28]}, 32'd1);
      repeat (20) step();
      chk("held_req_no_recap", {30'd0, status_word[31:30]}, 32'd0);
      snap_req = 1'b0; step();
      snap_req = 1'b1; step(); step();
      chk("recap_after_toggle", {28'd0, status_word[31:28]}, 32'hD);
      snap_req = 1'b0; step(); step();
      chk("release_clears_timeout", {31'd0, status_word[28]}, 32'd0);

      // Frame counter saturation, then release keeps only post-capture pulses.
      snap_req = 1'b0;
      do_reset();
      frame_done = 1'b1;
      repeat (70000) step();
      frame_done = 1'b0; step();
      chk("frame_cnt_saturated", {16'd0, status_word[15:0]}, 32'h0000_FFFF);
      snap_req = 1'b1; step(); step();
      chk("snap_cnt_saturated", {16'd0, status_word[15:0]}, 32'h0000_FFFF);
      snap_req = 1'b0; step();
      frame_done = 1'b1; step();
      frame_done = 1'b0; step();
      chk("cnt_after_release", {16'd0, status_word[15:0]}, 32'h0000_0001);

      // Reset in HOLD clears outputs immediately; held request stays disarmed.
      snap_req = 1'b0;
      do_reset();
      err_in = 8'h10; step();
      err_in = 8'h00; snap_req = 1'b1; step(); step(); step();
      chk("in_hold_before_reset", {31'd0, status_word[31]}, 32'd1);
      #2 reset_n = 1'b0;
      #1;
      chk("async_reset_word", status_word, 32'd0);
      chk("async_reset_pend", {31'd0, err_pending}, 32'd0);
      model_reset();
      @(negedge clk);
      reset_n = 1'b1;
      repeat (5) step();
      chk("post_reset_no_cap", {31'd0, status_word[31]}, 32'd0);
      snap_req = 1'b0; step();
      snap_req = 1'b1; step(); step();
      chk("post_reset_cap", {29'd0, status_word[31:29]}, 32'd5);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
